dma_fifo_device: RTL and testbench

- Parametrised successor to the single-register DMA device: a 16-bit peripheral-bus slave that moves blocks between memory and a FIFO through the DMA controller.
- Read mode (memory->device): the DMA fills the FIFO and the CPU pops it.
- Write mode (device->memory): the CPU prefills the FIFO and the DMA drains it.
- Explicit FSM, transfer counter, sticky status flags, abort/flush, completion interrupt.

---
 rtl/dma_fifo_device_if.sv | 31 +++
 rtl/dma_fifo_device.sv | 223 ++++++++++++++++++++++
 tb/tb_dma_fifo_device.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_fifo_device_if.sv
// Bus bundle for dma_fifo_device: peripheral-bus slave port plus DMA controller handshake.
// The slave modport is the device side; the master modport is the CPU/DMA side.
interface dma_fifo_device_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic        dma_rqst;
    logic        dma_rd_wr;
    logic [15:0] dma_start_address;
    logic [15:0] dma_num_words;
    logic        dev_ack;
    logic [15:0] dev_out;
    logic [15:0] dev_in;
    logic        dma_ack;
    logic        dma_end_flag;
    logic        irq;

    modport slave (
        input  per_addr, per_din, per_en, per_we, dev_in, dma_ack, dma_end_flag,
        output per_dout, dma_rqst, dma_rd_wr, dma_start_address, dma_num_words,
               dev_ack, dev_out, irq
    );

    modport master (
        output per_addr, per_din, per_en, per_we, dev_in, dma_ack, dma_end_flag,
        input  per_dout, dma_rqst, dma_rd_wr, dma_start_address, dma_num_words,
               dev_ack, dev_out, irq
    );
endinterface

// File: rtl/dma_fifo_device.sv
// DMA FIFO peripheral: register block, IDLE/RUN transfer FSM and a 2^FIFO_AW word FIFO.
// Optional completion interrupt enabled by defining DMA_FIFO_DEVICE_IRQ_EN.
module dma_fifo_device #(
    parameter logic [14:0] BASE_ADDR = 15'h0100,
    parameter int          DEC_WD    = 4,
    parameter int          FIFO_AW   = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    dma_fifo_device_if.slave   bus
);
    localparam int                DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  LVL_FULL = DEPTH[FIFO_AW:0];
    localparam logic [FIFO_AW:0]  LVL_ONE  = (FIFO_AW+1)'(1'b1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1'b1);

    localparam logic [DEC_WD-2:0] W_START  = (DEC_WD-1)'(3'd0);
    localparam logic [DEC_WD-2:0] W_NWORDS = (DEC_WD-1)'(3'd1);
    localparam logic [DEC_WD-2:0] W_CONFIG = (DEC_WD-1)'(3'd2);
    localparam logic [DEC_WD-2:0] W_STATUS = (DEC_WD-1)'(3'd3);
    localparam logic [DEC_WD-2:0] W_DATA   = (DEC_WD-1)'(3'd4);
    localparam logic [DEC_WD-2:0] W_LEVEL  = (DEC_WD-1)'(3'd5);
    localparam logic [DEC_WD-2:0] W_XFER   = (DEC_WD-1)'(3'd6);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t              state_r, state_nxt_s;
    logic [15:0]         start_addr_r, n_words_r, xfer_cnt_r;
    logic                rd_wr_r, irq_en_r, irq_r;
    logic                done_r, ovf_r, unf_r, abt_r, end_flag_r;
    logic [15:0]         mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [FIFO_AW:0]    level_r;

    logic [DEC_WD-2:0]   word_s;
    logic                reg_sel_s, wr_s, rd_s;
    logic                wr_cfg_s, wr_status_s, rd_data_s, wr_data_s;
    logic                start_p_s, abort_p_s, flush_s;
    logic                busy_s, xfer_s, full_s, empty_s, end_rise_s, last_s;
    logic                push_req_s, pop_req_s, push_ok_s, pop_ok_s, ovf_evt_s, unf_evt_s;
    logic [15:0]         push_data_s, head_s, rdata_s;
    logic                set_done_s, set_abt_s, clr_cnt_s;

    // Address decode and FIFO request steering; DMA and CPU always use opposite FIFO ends.
    always_comb begin
        word_s      = bus.per_addr[DEC_WD-2:0];
        reg_sel_s   = bus.per_en & (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
        wr_s        = reg_sel_s & (bus.per_we != 2'b00);
        rd_s        = reg_sel_s & (bus.per_we == 2'b00);
        wr_cfg_s    = wr_s & (word_s == W_CONFIG);
        wr_status_s = wr_s & (word_s == W_STATUS);
        wr_data_s   = wr_s & (word_s == W_DATA);
        rd_data_s   = rd_s & (word_s == W_DATA);
        start_p_s   = wr_cfg_s & bus.per_din[0];
        abort_p_s   = wr_cfg_s & bus.per_din[1];
        flush_s     = wr_cfg_s & (bus.per_din[3] | bus.per_din[1]);
        busy_s      = (state_r == ST_RUN);
        xfer_s      = busy_s & bus.dma_ack;
        full_s      = (level_r == LVL_FULL);
        empty_s     = (level_r == {(FIFO_AW+1){1'b0}});
        end_rise_s  = bus.dma_end_flag & ~end_flag_r;
        last_s      = xfer_s & ((xfer_cnt_r + 16'd1) == n_words_r);
        head_s      = mem[rd_ptr_r];
        push_req_s  = rd_wr_r ? xfer_s : wr_data_s;
        pop_req_s   = rd_wr_r ? rd_data_s : xfer_s;
        push_data_s = rd_wr_r ? bus.dev_in : bus.per_din;
        pop_ok_s    = pop_req_s & ~empty_s;
        // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
        push_ok_s   = push_req_s & (~full_s | pop_ok_s);
        ovf_evt_s   = push_req_s & ~push_ok_s;
        unf_evt_s   = pop_req_s & empty_s;
    end

    // Next-state logic; ABORT takes precedence over completion on the same edge.
    always_comb begin
        state_nxt_s = state_r;
        set_done_s  = 1'b0;
        set_abt_s   = 1'b0;
        clr_cnt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_p_s) begin
                    if (n_words_r != 16'h0000) begin
                        state_nxt_s = ST_RUN;
                        clr_cnt_s   = 1'b1;
                    end else begin
                        set_done_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_p_s) begin
                    state_nxt_s = ST_IDLE;
                    set_abt_s   = 1'b1;
                end else if (last_s | end_rise_s) begin
                    state_nxt_s = ST_IDLE;
                    set_done_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= ST_IDLE;
        else          state_r <= state_nxt_s;
    end

    // Software-visible configuration registers; direction is frozen while a transfer runs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_addr_r <= 16'h0000;
            n_words_r    <= 16'h0000;
            rd_wr_r      <= 1'b0;
            irq_en_r     <= 1'b0;
        end else begin
            if (wr_s && word_s == W_START)  start_addr_r <= bus.per_din;
            if (wr_s && word_s == W_NWORDS) n_words_r    <= bus.per_din;
            if (wr_cfg_s && !busy_s)        rd_wr_r      <= bus.per_din[2];
`ifdef DMA_FIFO_DEVICE_IRQ_EN
            if (wr_cfg_s)                   irq_en_r     <= bus.per_din[4];
`endif
        end
    end

    // Sticky status flags: a set event wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
            abt_r  <= 1'b0;
        end else begin
            done_r <= set_done_s | (done_r & ~(wr_status_s & bus.per_din[1]));
            ovf_r  <= ovf_evt_s  | (ovf_r  & ~(wr_status_s & bus.per_din[2]));
            unf_r  <= unf_evt_s  | (unf_r  & ~(wr_status_s & bus.per_din[3]));
            abt_r  <= set_abt_s  | (abt_r  & ~(wr_status_s & bus.per_din[4]));
        end
    end

    // Transfer counter and end-flag edge detector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xfer_cnt_r <= 16'h0000;
            end_flag_r <= 1'b0;
        end else begin
            end_flag_r <= bus.dma_end_flag;
            if (clr_cnt_s)   xfer_cnt_r <= 16'h0000;
            else if (xfer_s) xfer_cnt_r <= xfer_cnt_r + 16'd1;
        end
    end

    // FIFO pointers and occupancy; flush overrides any same-cycle push or pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            level_r  <= {(FIFO_AW+1){1'b0}};
        end else if (flush_s) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            level_r  <= {(FIFO_AW+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // FIFO storage; contents are never observed while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem[wr_ptr_r] <= push_data_s;
    end

    // Completion interrupt register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_r <= 1'b0;
        else          irq_r <= done_r & irq_en_r;
    end

    // Register read mux.
    always_comb begin
        rdata_s = 16'h0000;
        if (rd_s) begin
            case (word_s)
                W_START:  rdata_s = start_addr_r;
                W_NWORDS: rdata_s = n_words_r;
                W_CONFIG: rdata_s = {11'h000, irq_en_r, 1'b0, rd_wr_r, 2'b00};
                W_STATUS: rdata_s = {11'h000, abt_r, unf_r, ovf_r, done_r, busy_s};
                W_DATA:   rdata_s = (rd_wr_r & ~empty_s) ? head_s : 16'h0000;
                W_LEVEL:  rdata_s = 16'(level_r);
                W_XFER:   rdata_s = xfer_cnt_r;
                default:  rdata_s = 16'h0000;
            endcase
        end else begin
            rdata_s = 16'h0000;
        end
    end

    assign bus.per_dout          = rdata_s;
    assign bus.dma_rqst          = busy_s;
    assign bus.dma_rd_wr         = rd_wr_r;
    assign bus.dma_start_address = start_addr_r;
    assign bus.dma_num_words     = n_words_r;
    assign bus.dev_ack           = busy_s & (rd_wr_r ? ~full_s : ~empty_s);
    assign bus.dev_out           = (~rd_wr_r & ~empty_s) ? head_s : 16'h0000;
`ifdef DMA_FIFO_DEVICE_IRQ_EN
    assign bus.irq               = irq_r;
`else
    assign bus.irq               = 1'b0;
`endif
endmodule

// File: tb/tb_dma_fifo_device.sv
// Directed testbench for dma_fifo_device with a 4-deep FIFO (FIFO_AW=2).
module tb_dma_fifo_device;
    localparam int FIFO_AW = 2;
    localparam logic [13:0] A_START  = 14'h0080;
    localparam logic [13:0] A_NWORDS = 14'h0081;
    localparam logic [13:0] A_CONFIG = 14'h0082;
    localparam logic [13:0] A_STATUS = 14'h0083;
    localparam logic [13:0] A_DATA   = 14'h0084;
    localparam logic [13:0] A_LEVEL  = 14'h0085;
    localparam logic [13:0] A_XFER   = 14'h0086;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [15:0] rd;

    always #5 clk = ~clk;

    dma_fifo_device_if bus_if();

    dma_fifo_device #(.BASE_ADDR(15'h0100), .DEC_WD(4), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus_if.slave)
    );

    task automatic cpu_write(input logic [13:0] a, input logic [15:0] d);
        @(negedge clk);
        bus_if.per_en = 1'b1; bus_if.per_we = 2'b11; bus_if.per_addr = a; bus_if.per_din = d;
        @(posedge clk); #1;
        bus_if.per_en = 1'b0; bus_if.per_we = 2'b00;
    endtask

    task automatic cpu_read(input logic [13:0] a, output logic [15:0] d);
        @(negedge clk);
        bus_if.per_en = 1'b1; bus_if.per_we = 2'b00; bus_if.per_addr = a;
        #1 d = bus_if.per_dout;
        @(posedge clk); #1;
        bus_if.per_en = 1'b0;
    endtask

    task automatic dma_word(input logic [15:0] d);
        @(negedge clk);
        bus_if.dma_ack = 1'b1; bus_if.dev_in = d;
        @(posedge clk); #1;
        bus_if.dma_ack = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++; if ({bus_if.dma_rqst, bus_if.dma_rd_wr, bus_if.dev_ack, bus_if.irq} !== 4'b0000) begin miscompares++; $display("FAIL reset_ctl_in_reset: got %b expected 0000", {bus_if.dma_rqst, bus_if.dma_rd_wr, bus_if.dev_ack, bus_if.irq}); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (bus_if.per_dout !== 16'h0000) begin miscompares++; $display("FAIL reset_per_dout: got %h expected 0000", bus_if.per_dout); end
        vectors++; if ({bus_if.dma_start_address, bus_if.dma_num_words, bus_if.dev_out} !== 48'h0) begin miscompares++; $display("FAIL reset_words: got %h expected 0", {bus_if.dma_start_address, bus_if.dma_num_words, bus_if.dev_out}); end
        cpu_read(A_STATUS, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL reset_status: got %h expected 0000", rd); end
        cpu_read(A_LEVEL, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL reset_level: got %h expected 0000", rd); end
        cpu_read(A_CONFIG, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL reset_config: got %h expected 0000", rd); end
    endtask

    task automatic test_read_mode();
        logic [15:0] exp_words [3];
        exp_words[0] = 16'h1111; exp_words[1] = 16'h2222; exp_words[2] = 16'h3333;
        cpu_write(A_START, 16'h0200);
        cpu_write(A_NWORDS, 16'h0003);
        cpu_write(A_CONFIG, 16'h0005);
        vectors++; if ({bus_if.dma_rqst, bus_if.dev_ack, bus_if.dma_rd_wr} !== 3'b111) begin miscompares++; $display("FAIL rd_rqst_ack_dir: got %b expected 111", {bus_if.dma_rqst, bus_if.dev_ack, bus_if.dma_rd_wr}); end
        vectors++; if ({bus_if.dma_start_address, bus_if.dma_num_words} !== {16'h0200, 16'h0003}) begin miscompares++; $display("FAIL rd_addr_nwords: got %h expected 02000003", {bus_if.dma_start_address, bus_if.dma_num_words}); end
        dma_word(exp_words[0]);
        dma_word(exp_words[1]);
        vectors++; if (bus_if.dma_rqst !== 1'b1) begin miscompares++; $display("FAIL rd_rqst_mid: got %b expected 1", bus_if.dma_rqst); end
        dma_word(exp_words[2]);
        vectors++; if (bus_if.dma_rqst !== 1'b0) begin miscompares++; $display("FAIL rd_rqst_after_last: got %b expected 0", bus_if.dma_rqst); end
        cpu_read(A_LEVEL, rd);
        vectors++; if (rd !== 16'h0003) begin miscompares++; $display("FAIL rd_level: got %h expected 0003", rd); end
        cpu_read(A_STATUS, rd);
        vectors++; if (rd !== 16'h0002) begin miscompares++; $display("FAIL rd_status_done: got %h expected 0002", rd); end
        cpu_read(A_XFER, rd);
        vectors++; if (rd !== 16'h0003) begin miscompares++; $display("FAIL rd_xfer_cnt: got %h expected 0003", rd); end
        for (int i = 0; i < 3; i++) begin
            cpu_read(A_DATA, rd);
            vectors++; if (rd !== exp_words[i]) begin miscompares++; $display("FAIL rd_data%0d: got %h expected %h", i, rd, exp_words[i]); end
        end
        cpu_read(A_DATA, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL rd_data_empty: got %h expected 0000", rd); end
        cpu_read(A_STATUS, rd);
        vectors++; if (rd !== 16'h000A) begin miscompares++; $display("FAIL rd_status_unf: got %h expected 000a", rd); end
        cpu_write(A_STATUS, 16'h001E);
        cpu_read(A_STATUS, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL rd_status_w1c: got %h expected 0000", rd); end
    endtask

    task automatic test_write_mode();
        cpu_write(A_CONFIG, 16'h0000);
        cpu_write(A_DATA, 16'hA5A5);
        cpu_write(A_DATA, 16'h5A5A);
        cpu_read(A_LEVEL, rd);
        vectors++; if (rd !== 16'h0002) begin miscompares++; $display("FAIL wr_prefill_level: got %h expected 0002", rd); end
        vectors++; if ({bus_if.dev_ack, bus_if.dev_out} !== {1'b0, 16'hA5A5}) begin miscompares++; $display("FAIL wr_idle_head: got %h expected 0a5a5", {bus_if.dev_ack, bus_if.dev_out}); end
        cpu_write(A_NWORDS, 16'h0002);
        cpu_write(A_CONFIG, 16'h0001);
        vectors++; if ({bus_if.dma_rqst, bus_if.dev_ack, bus_if.dma_rd_wr} !== 3'b110) begin miscompares++; $display("FAIL wr_rqst_ack_dir: got %b expected 110", {bus_if.dma_rqst, bus_if.dev_ack, bus_if.dma_rd_wr}); end
        vectors++; if (bus_if.dev_out !== 16'hA5A5) begin miscompares++; $display("FAIL wr_dev_out0: got %h expected a5a5", bus_if.dev_out); end
        dma_word(16'h0000);
        vectors++; if (bus_if.dev_out !== 16'h5A5A) begin miscompares++; $display("FAIL wr_dev_out1: got %h expected 5a5a", bus_if.dev_out); end
        dma_word(16'h0000);
        vectors++; if ({bus_if.dma_rqst, bus_if.dev_out} !== 17'h0) begin miscompares++; $display("FAIL wr_end_outputs: got %h expected 0", {bus_if.dma_rqst, bus_if.dev_out}); end
        cpu_read(A_LEVEL, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL wr_level: got %h expected 0000", rd); end
        cpu_read(A_XFER, rd);
        vectors++; if (rd !== 16'h0002) begin miscompares++; $display("FAIL wr_xfer_cnt: got %h expected 0002", rd); end
        cpu_read(A_STATUS, rd);
        vectors++; if (rd !== 16'h0002) begin miscompares++; $display("FAIL wr_status: got %h expected 0002", rd); end
        cpu_write(A_STATUS, 16'h001E);
    endtask

    task automatic test_overflow();
        cpu_write(A_CONFIG, 16'h0004);
        cpu_write(A_NWORDS, 16'h0006);
        cpu_write(A_CONFIG, 16'h0005);
        for (int i = 1; i <= 4; i++) dma_word(16'h0101 * i[15:0]);
        vectors++; if ({bus_if.dma_rqst, bus_if.dev_ack} !== 2'b10) begin miscompares++; $display("FAIL ovf_full_ack: got %b expected 10", {bus_if.dma_rqst, bus_if.dev_ack}); end
        cpu_read(A_LEVEL, rd);
        vectors++; if (rd !== 16'h0004) begin miscompares++; $display("FAIL ovf_level_full: got %h expected 0004", rd); end
        dma_word(16'hEEEE);
        cpu_read(A_LEVEL, rd);
        vectors++; if (rd !== 16'h0004) begin miscompares++; $display("FAIL ovf_level_after: got %h expected 0004", rd); end
        cpu_read(A_STATUS, rd);
        vectors++; if (rd !== 16'h0005) begin miscompares++; $display("FAIL ovf_status: got %h expected 0005", rd); end
        cpu_read(A_XFER, rd);
        vectors++; if (rd !== 16'h0005) begin miscompares++; $display("FAIL ovf_xfer_cnt: got %h expected 0005", rd); end
        cpu_write(A_CONFIG, 16'h0002);
        vectors++; if ({bus_if.dma_rqst, bus_if.dma_rd_wr} !== 2'b01) begin miscompares++; $display("FAIL ovf_abort_dir_kept: got %b expected 01", {bus_if.dma_rqst, bus_if.dma_rd_wr}); end
        cpu_read(A_STATUS, rd);
        vectors++; if (rd !== 16'h0014) begin miscompares++; $display("FAIL ovf_abort_status: got %h expected 0014", rd); end
        cpu_write(A_STATUS, 16'h001E);
    endtask

    task automatic test_abort();
        cpu_write(A_NWORDS, 16'h0004);
        cpu_write(A_CONFIG, 16'h0005);
        dma_word(16'h1234);
        cpu_write(A_CONFIG, 16'h0006);
        vectors++; if (bus_if.dma_rqst !== 1'b0) begin miscompares++; $display("FAIL abt_rqst: got %b expected 0", bus_if.dma_rqst); end
        cpu_read(A_STATUS, rd);
        vectors++; if (rd !== 16'h0010) begin miscompares++; $display("FAIL abt_status: got %h expected 0010", rd); end
        cpu_read(A_LEVEL, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL abt_level: got %h expected 0000", rd); end
        cpu_read(A_XFER, rd);
        vectors++; if (rd !== 16'h0001) begin miscompares++; $display("FAIL abt_xfer_cnt: got %h expected 0001", rd); end
        cpu_write(A_STATUS, 16'h001E);
    endtask

    task automatic test_zero_words();
        logic [15:0] exp_cfg;
        logic        exp_irq;
`ifdef DMA_FIFO_DEVICE_IRQ_EN
        exp_cfg = 16'h0014; exp_irq = 1'b1;
`else
        exp_cfg = 16'h0004; exp_irq = 1'b0;
`endif
        cpu_write(A_NWORDS, 16'h0000);
        cpu_write(A_CONFIG, 16'h0014);
        cpu_read(A_CONFIG, rd);
        vectors++; if (rd !== exp_cfg) begin miscompares++; $display("FAIL zw_config: got %h expected %h", rd, exp_cfg); end
        cpu_write(A_CONFIG, 16'h0015);
        vectors++; if ({bus_if.dma_rqst, bus_if.irq} !== 2'b00) begin miscompares++; $display("FAIL zw_same_cycle: got %b expected 00", {bus_if.dma_rqst, bus_if.irq}); end
        @(posedge clk); #1;
        vectors++; if ({bus_if.dma_rqst, bus_if.irq} !== {1'b0, exp_irq}) begin miscompares++; $display("FAIL zw_irq: got %b expected %b", {bus_if.dma_rqst, bus_if.irq}, {1'b0, exp_irq}); end
        cpu_read(A_STATUS, rd);
        vectors++; if (rd !== 16'h0002) begin miscompares++; $display("FAIL zw_status: got %h expected 0002", rd); end
        cpu_write(A_STATUS, 16'h0002);
        @(posedge clk); #1;
        vectors++; if (bus_if.irq !== 1'b0) begin miscompares++; $display("FAIL zw_irq_cleared: got %b expected 0", bus_if.irq); end
        cpu_write(A_CONFIG, 16'h0004);
    endtask

    task automatic test_simultaneous();
        cpu_write(A_NWORDS, 16'h0003);
        cpu_write(A_CONFIG, 16'h0005);
        dma_word(16'hAAAA);
        dma_word(16'hBBBB);
        @(negedge clk);
        bus_if.dma_ack = 1'b1; bus_if.dev_in = 16'hCCCC;
        bus_if.per_en = 1'b1; bus_if.per_we = 2'b00; bus_if.per_addr = A_DATA;
        #1 rd = bus_if.per_dout;
        @(posedge clk); #1;
        bus_if.dma_ack = 1'b0; bus_if.per_en = 1'b0;
        vectors++; if (rd !== 16'hAAAA) begin miscompares++; $display("FAIL sim_pop_oldest: got %h expected aaaa", rd); end
        cpu_read(A_LEVEL, rd);
        vectors++; if (rd !== 16'h0002) begin miscompares++; $display("FAIL sim_level: got %h expected 0002", rd); end
        cpu_read(A_DATA, rd);
        vectors++; if (rd !== 16'hBBBB) begin miscompares++; $display("FAIL sim_data1: got %h expected bbbb", rd); end
        cpu_read(A_DATA, rd);
        vectors++; if (rd !== 16'hCCCC) begin miscompares++; $display("FAIL sim_data2: got %h expected cccc", rd); end
        cpu_read(A_STATUS, rd);
        vectors++; if (rd !== 16'h0002) begin miscompares++; $display("FAIL sim_status: got %h expected 0002", rd); end
        cpu_write(A_STATUS, 16'h001E);
    endtask

    task automatic test_end_flag_flush();
        cpu_write(A_NWORDS, 16'h0005);
        cpu_write(A_CONFIG, 16'h0005);
        dma_word(16'h4321);
        @(negedge clk); bus_if.dma_end_flag = 1'b1;
        @(posedge clk); #1;
        vectors++; if (bus_if.dma_rqst !== 1'b0) begin miscompares++; $display("FAIL end_rqst: got %b expected 0", bus_if.dma_rqst); end
        bus_if.dma_end_flag = 1'b0;
        cpu_read(A_STATUS, rd);
        vectors++; if (rd !== 16'h0002) begin miscompares++; $display("FAIL end_status: got %h expected 0002", rd); end
        cpu_read(A_LEVEL, rd);
        vectors++; if (rd !== 16'h0001) begin miscompares++; $display("FAIL end_level: got %h expected 0001", rd); end
        cpu_write(A_CONFIG, 16'h000C);
        cpu_read(A_LEVEL, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL flush_level: got %h expected 0000", rd); end
        cpu_write(A_STATUS, 16'h001E);
    endtask

    task automatic test_async_reset();
        cpu_write(A_NWORDS, 16'h0004);
        cpu_write(A_CONFIG, 16'h0005);
        dma_word(16'h5555);
        @(negedge clk); #2 reset_n = 1'b0;
        #1;
        vectors++; if ({bus_if.dma_rqst, bus_if.dma_rd_wr, bus_if.dma_num_words} !== 18'h0) begin miscompares++; $display("FAIL arst_outputs: got %h expected 0", {bus_if.dma_rqst, bus_if.dma_rd_wr, bus_if.dma_num_words}); end
        @(negedge clk); reset_n = 1'b1;
        cpu_read(A_LEVEL, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL arst_level: got %h expected 0000", rd); end
    endtask

    initial begin
        bus_if.per_addr = 14'h0000; bus_if.per_din = 16'h0000; bus_if.per_en = 1'b0;
        bus_if.per_we = 2'b00; bus_if.dev_in = 16'h0000; bus_if.dma_ack = 1'b0;
        bus_if.dma_end_flag = 1'b0;
        test_reset();
        test_read_mode();
        test_write_mode();
        test_overflow();
        test_abort();
        test_zero_words();
        test_simultaneous();
        test_end_flag_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
